// File: rtl/reg_file.sv
// Operand-fetch register file: 16 data registers, each paired with a dirty (pending-write) bit.
// Accepts one request at a time and holds its response until the requester takes it.
module reg_file #(
   parameter int DATA_WIDTH    = 32,
   parameter int REG_CMD_WIDTH = 2,
   parameter int NUM_REGS      = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [3:0]               i_reg,
   input  logic [DATA_WIDTH-1:0]    i_data,
   input  logic [REG_CMD_WIDTH-1:0] i_cmd,
   input  logic                     i_valid,
   input  logic                     i_res_ready,
   output logic [DATA_WIDTH-1:0]    o_data,
   output logic                     o_res_valid,
   output logic                     o_ready
);

   localparam logic [REG_CMD_WIDTH-1:0] CMD_READ  = REG_CMD_WIDTH'(0);
   localparam logic [REG_CMD_WIDTH-1:0] CMD_WRITE = REG_CMD_WIDTH'(1);
   localparam logic [REG_CMD_WIDTH-1:0] CMD_CHECK = REG_CMD_WIDTH'(2);
   localparam logic [REG_CMD_WIDTH-1:0] CMD_LOCK  = REG_CMD_WIDTH'(3);

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [NUM_REGS-1:0]   dirty;
   logic [DATA_WIDTH-1:0] result;
   logic                  do_write;
   logic                  do_lock;
   logic                  accept;

   // A held response blocks new requests, so at most one is ever in flight.
   assign o_ready = !o_res_valid;
   assign accept  = i_valid && !o_res_valid;

   always_comb begin
      result   = '0;
      do_write = 1'b0;
      do_lock  = 1'b0;
      case (i_cmd)
         CMD_READ:  result = regs[i_reg];
         CMD_WRITE: begin
            result   = i_data;
            do_write = 1'b1;
         end
         CMD_CHECK: result = DATA_WIDTH'(dirty[i_reg]);
         CMD_LOCK: begin
            result  = DATA_WIDTH'(dirty[i_reg]);
            do_lock = 1'b1;
         end
         default: result = '0;
      endcase
   end

   // Accept and consume are mutually exclusive because accept requires no pending response.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            regs[k] <= '0;
         end
         dirty       <= '0;
         o_data      <= '0;
         o_res_valid <= 1'b0;
      end else if (accept) begin
         o_data      <= result;
         o_res_valid <= 1'b1;
         if (do_write) begin
            regs[i_reg]  <= i_data;
            dirty[i_reg] <= 1'b0;
         end
         if (do_lock) begin
            dirty[i_reg] <= 1'b1;
         end
      end else if (o_res_valid && i_res_ready) begin
         o_res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: expected responses queue up as requests go out and are
// popped when the response appears.
module tb_reg_file;

   localparam logic [1:0] READ  = 2'd0;
   localparam logic [1:0] WRITE = 2'd1;
   localparam logic [1:0] CHECK = 2'd2;
   localparam logic [1:0] LOCK  = 2'd3;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  i_reg;
   logic [31:0] i_data;
   logic [1:0]  i_cmd;
   logic        i_valid;
   logic        i_res_ready;
   logic [31:0] o_data;
   logic        o_res_valid;
   logic        o_ready;

   logic [31:0] sb [$];
   int          checks = 0;
   int          errors = 0;

   reg_file #(.DATA_WIDTH(32), .REG_CMD_WIDTH(2), .NUM_REGS(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .i_reg       (i_reg),
      .i_data      (i_data),
      .i_cmd       (i_cmd),
      .i_valid     (i_valid),
      .i_res_ready (i_res_ready),
      .o_data      (o_data),
      .o_res_valid (o_res_valid),
      .o_ready     (o_ready)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called just after the accept edge; the response must already be up at the next negedge.
   task automatic check_output(input string tag);
      logic [31:0] exp;
      @(negedge clk);
      check_eq({tag, " valid"}, 32'(o_res_valid), 32'd1);
      check_eq({tag, " ready"}, 32'(o_ready), 32'd0);
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("[TB] FAIL %s: observed=response expected=no entry in scoreboard", tag);
      end else begin
         exp = sb.pop_front();
         check_eq({tag, " data"}, o_data, exp);
      end
   endtask

   // Entered and left at a negedge with o_ready high and i_res_ready high.
   task automatic apply_stimulus(input logic [1:0] cmd, input logic [3:0] idx,
                                 input logic [31:0] data, input logic [31:0] exp,
                                 input string tag);
      i_cmd   = cmd;
      i_reg   = idx;
      i_data  = data;
      i_valid = 1'b1;
      sb.push_back(exp);
      @(posedge clk);
      #1 i_valid = 1'b0;
      check_output(tag);
      @(negedge clk);
   endtask

   initial begin
      reset       = 1'b1;
      i_reg       = '0;
      i_data      = '0;
      i_cmd       = READ;
      i_valid     = 1'b0;
      i_res_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_eq("reset valid", 32'(o_res_valid), 32'd0);
      check_eq("reset ready", 32'(o_ready), 32'd1);
      check_eq("reset data", o_data, 32'd0);

      apply_stimulus(WRITE, 4'd3, 32'hDEADBEEF, 32'hDEADBEEF, "write r3");
      apply_stimulus(READ,  4'd3, 32'h0, 32'hDEADBEEF, "read r3");
      apply_stimulus(READ,  4'd4, 32'h0, 32'h0, "read r4");

      apply_stimulus(LOCK,  4'd5, 32'h0, 32'd0, "lock r5 first");
      apply_stimulus(CHECK, 4'd5, 32'h0, 32'd1, "check r5 locked");
      apply_stimulus(WRITE, 4'd5, 32'h12, 32'h12, "write r5");
      apply_stimulus(CHECK, 4'd5, 32'h0, 32'd0, "check r5 cleared");
      apply_stimulus(LOCK,  4'd5, 32'h0, 32'd0, "lock r5 again");
      apply_stimulus(LOCK,  4'd5, 32'h0, 32'd1, "lock r5 twice");
      apply_stimulus(READ,  4'd5, 32'h0, 32'h12, "read r5 after lock");

      // Backpressure: a pending WRITE request must not disturb the held READ response.
      i_res_ready = 1'b0;
      i_cmd       = READ;
      i_reg       = 4'd3;
      i_valid     = 1'b1;
      sb.push_back(32'hDEADBEEF);
      @(posedge clk);
      #1;
      i_cmd  = WRITE;
      i_data = 32'h55;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check_eq("hold valid", 32'(o_res_valid), 32'd1);
         check_eq("hold ready", 32'(o_ready), 32'd0);
         check_eq("hold data", o_data, sb[0]);
      end
      i_valid     = 1'b0;
      i_res_ready = 1'b1;
      void'(sb.pop_front());
      @(negedge clk);
      check_eq("consumed valid", 32'(o_res_valid), 32'd0);
      apply_stimulus(READ, 4'd3, 32'h0, 32'hDEADBEEF, "r3 unchanged");

      // Throughput: valid held high gives a response every other cycle.
      i_cmd   = READ;
      i_reg   = 4'd3;
      i_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         sb.push_back(32'hDEADBEEF);
         @(negedge clk);
         check_eq("stream valid", 32'(o_res_valid), 32'd1);
         check_eq("stream ready", 32'(o_ready), 32'd0);
         check_eq("stream data", o_data, sb.pop_front());
         @(negedge clk);
         check_eq("stream gap valid", 32'(o_res_valid), 32'd0);
         check_eq("stream gap ready", 32'(o_ready), 32'd1);
      end
      i_valid = 1'b0;
      @(negedge clk);

      // Reset while a response is still pending.
      apply_stimulus(LOCK,  4'd7, 32'h0, 32'd0, "lock r7");
      apply_stimulus(WRITE, 4'd1, 32'hAA, 32'hAA, "write r1");
      i_res_ready = 1'b0;
      i_cmd       = READ;
      i_reg       = 4'd1;
      i_valid     = 1'b1;
      @(posedge clk);
      #1 i_valid = 1'b0;
      @(negedge clk);
      check_eq("pre-reset valid", 32'(o_res_valid), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset       = 1'b0;
      i_res_ready = 1'b1;
      check_eq("mid reset valid", 32'(o_res_valid), 32'd0);
      check_eq("mid reset ready", 32'(o_ready), 32'd1);
      check_eq("mid reset data", o_data, 32'd0);
      apply_stimulus(CHECK, 4'd7, 32'h0, 32'd0, "check r7 after reset");
      apply_stimulus(READ,  4'd1, 32'h0, 32'd0, "read r1 after reset");
      apply_stimulus(READ,  4'd3, 32'h0, 32'd0, "read r3 after reset");

      // Index sweep, including r0 and r15.
      for (int r = 0; r < 16; r++) begin
         apply_stimulus(WRITE, 4'(r), 32'h11111111 * 32'(r), 32'h11111111 * 32'(r), "sweep write");
      end
      for (int r = 0; r < 16; r++) begin
         apply_stimulus(READ, 4'(r), 32'h0, 32'h11111111 * 32'(r), "sweep read");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
